// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and a field-level view of a word.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;

  typedef struct {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] w);
    fp32_t f;
    f.sign = w[31];
    f.exp  = w[30:23];
    f.frac = w[22:0];
    return f;
  endfunction

endpackage

// File: rtl/fp32_norm_round.sv
// Normalises a 48-bit significand product, rounds to nearest-even and flags
// exponent overflow/underflow. Purely combinational.
module fp32_norm_round
  import fp32_pkg::*;
(
  input  logic [47:0]       prod_i,
  input  logic signed [9:0] exp_i,
  input  logic              sign_i,
  output logic [23:0]       mant_o,
  output logic [7:0]        exp_o,
  output logic              ovf_o,
  output logic              unf_o
);

  // Returns {carry, rounded 24-bit significand}.
  function automatic logic [24:0] round_rne(input logic [23:0] sig,
                                            input logic        guard,
                                            input logic        sticky);
    return {1'b0, sig} + {24'd0, guard & (sticky | sig[0])};
  endfunction

  logic              norm;
  logic [23:0]       sig;
  logic              guard;
  logic              sticky;
  logic [24:0]       rnd;
  logic signed [9:0] exp_r;

  always_comb begin
    norm = prod_i[47];
    if (norm) begin
      sig    = prod_i[47:24];
      guard  = prod_i[23];
      sticky = |prod_i[22:0];
    end else begin
      sig    = prod_i[46:23];
      guard  = prod_i[22];
      sticky = |prod_i[21:0];
    end
    rnd = round_rne(sig, guard, sticky);
    // A carry out of rounding leaves an all-zero fraction, so only the exponent moves.
    exp_r  = exp_i + $signed({9'd0, norm}) + $signed({9'd0, rnd[24]});
    mant_o = {sign_i, (rnd[24] ? rnd[23:1] : rnd[22:0])};
    exp_o  = exp_r[7:0];
    ovf_o  = (exp_r >= 10'sd255);
    unf_o  = (exp_r <= 10'sd0);
  end

endmodule

// File: rtl/multiplication.sv
// Binary32 multiplier, flush-to-zero, round-to-nearest-even, registered outputs.
// Define MULTIPLICATION_PIPE2_EN for a two-stage (latency 2) variant.
module multiplication
  import fp32_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic [31:0] result
);

  fp32_t             a_f;
  fp32_t             b_f;
  logic              sign_p0;
  logic              exc_p0;
  logic              zero_p0;
  logic [47:0]       prod_p0;
  logic signed [9:0] exp_p0;

  always_comb begin
    a_f = fp32_unpack(a_operand);
    b_f = fp32_unpack(b_operand);
  end

  assign sign_p0 = a_f.sign ^ b_f.sign;
  assign exc_p0  = (a_f.exp == 8'hFF) | (b_f.exp == 8'hFF);
  assign zero_p0 = (a_f.exp == 8'h00) | (b_f.exp == 8'h00);
  assign prod_p0 = 48'({1'b1, a_f.frac}) * 48'({1'b1, b_f.frac});
  assign exp_p0  = $signed({2'b00, a_f.exp}) + $signed({2'b00, b_f.exp}) - 10'(BIAS);

  logic              sign_s;
  logic              exc_s;
  logic              zero_s;
  logic [47:0]       prod_s;
  logic signed [9:0] exp_s;

`ifdef MULTIPLICATION_PIPE2_EN
  logic              sign_p1_q;
  logic              exc_p1_q;
  logic              zero_p1_q;
  logic [47:0]       prod_p1_q;
  logic signed [9:0] exp_p1_q;

  // Stage 1 -> stage 2 boundary: raw product and special-case decode.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sign_p1_q <= 1'b0;
      exc_p1_q  <= 1'b0;
      zero_p1_q <= 1'b0;
      prod_p1_q <= '0;
      exp_p1_q  <= '0;
    end else begin
      sign_p1_q <= sign_p0;
      exc_p1_q  <= exc_p0;
      zero_p1_q <= zero_p0;
      prod_p1_q <= prod_p0;
      exp_p1_q  <= exp_p0;
    end
  end

  assign sign_s = sign_p1_q;
  assign exc_s  = exc_p1_q;
  assign zero_s = zero_p1_q;
  assign prod_s = prod_p1_q;
  assign exp_s  = exp_p1_q;
`else
  assign sign_s = sign_p0;
  assign exc_s  = exc_p0;
  assign zero_s = zero_p0;
  assign prod_s = prod_p0;
  assign exp_s  = exp_p0;
`endif

  logic [23:0] mant_n;
  logic [7:0]  exp_n;
  logic        ovf_n;
  logic        unf_n;

  fp32_norm_round u_norm_round (
    .prod_i (prod_s),
    .exp_i  (exp_s),
    .sign_i (sign_s),
    .mant_o (mant_n),
    .exp_o  (exp_n),
    .ovf_o  (ovf_n),
    .unf_o  (unf_n)
  );

  logic [31:0] result_d, result_q;
  logic        exc_d, exc_q;
  logic        ovf_d, ovf_q;
  logic        unf_d, unf_q;

  always_comb begin
    result_d = {mant_n[23], exp_n, mant_n[22:0]};
    exc_d    = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (exc_s) begin
      result_d = FP32_QNAN;
      exc_d    = 1'b1;
    end else if (zero_s) begin
      result_d = {mant_n[23], 31'd0};
    end else if (ovf_n) begin
      result_d = {mant_n[23], FP32_POS_INF[30:0]};
      ovf_d    = 1'b1;
    end else if (unf_n) begin
      result_d = {mant_n[23], 31'd0};
      unf_d    = 1'b1;
    end
  end

  // Output register boundary.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      result_q <= '0;
      exc_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      exc_q    <= exc_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign result    = result_q;
  assign Exception = exc_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_multiplication.sv
// Self-checking bench for the binary32 multiplier against an exact-integer reference.
module tb_multiplication;

`ifdef MULTIPLICATION_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_op = '0;
  logic [31:0] b_op = '0;
  logic        exc_o, ovf_o, unf_o;
  logic [31:0] res_o;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multiplication dut (
    .CLK       (clk),
    .RESET     (rst),
    .a_operand (a_op),
    .b_operand (b_op),
    .Exception (exc_o),
    .Overflow  (ovf_o),
    .Underflow (unf_o),
    .result    (res_o)
  );

  // Reference: exact integer product, rounded by remainder comparison.
  // Returns {Exception, Overflow, Underflow, result}.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    longint unsigned ma, mb, p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 255 || eb == 255) return {3'b100, 32'h7FC00000};
    if (ea == 0 || eb == 0) return {3'b000, s, 31'd0};
    ma = (64'd1 << 23) + 64'(a[22:0]);
    mb = (64'd1 << 23) + 64'(b[22:0]);
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    q  = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b001, s, 31'd0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[30:23] = 8'h00;
      1: w[30:23] = 8'hFF;
      2, 3: w[30:23] = 8'($urandom_range(180, 254));
      4, 5: w[30:23] = 8'($urandom_range(1, 70));
      default: w[30:23] = 8'($urandom_range(100, 154));
    endcase
    return w;
  endfunction

  // Called at posedge+1; applies a pair and returns outputs LAT edges later.
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, output logic [34:0] got);
    a_op = a;
    b_op = b;
    repeat (LAT) @(posedge clk);
    #1 got = {exc_o, ovf_o, unf_o, res_o};
  endtask

  task automatic test_reset();
    logic [34:0] got;
    rst  = 1'b1;
    a_op = 32'h40A00000;
    b_op = 32'h40A00000;
    #3;
    got = {exc_o, ovf_o, unf_o, res_o};
    vectors++;
    if (got !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", got, 35'd0);
    end
    repeat (2) @(posedge clk);
    #1 got = {exc_o, ovf_o, unf_o, res_o};
    vectors++;
    if (got !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_held got=%h want=%h", got, 35'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [12];
    logic [31:0] tb [12];
    logic [34:0] te [12];
    logic [34:0] got;
    ta = '{32'h40A00000, 32'h3F800000, 32'h3FC00000, 32'h7F000000, 32'hFF000000, 32'h00800000,
           32'h7F800000, 32'h00000000, 32'h7F800000, 32'h7FC12345, 32'h3F800000, 32'h80000000};
    tb = '{32'h40A00000, 32'hC0000000, 32'h3FC00000, 32'h40000000, 32'h40000000, 32'h00800000,
           32'h3F800000, 32'hC0400000, 32'h00000000, 32'h3F800000, 32'h007FFFFF, 32'h80000000};
    te = '{{3'b000, 32'h41C80000}, {3'b000, 32'hC0000000}, {3'b000, 32'h40100000},
           {3'b010, 32'h7F800000}, {3'b010, 32'hFF800000}, {3'b001, 32'h00000000},
           {3'b100, 32'h7FC00000}, {3'b000, 32'h80000000}, {3'b100, 32'h7FC00000},
           {3'b100, 32'h7FC00000}, {3'b000, 32'h00000000}, {3'b000, 32'h00000000}};
    for (int i = 0; i < 12; i++) begin
      run_pair(ta[i], tb[i], got);
      vectors++;
      if (got !== te[i]) begin
        miscompares++;
        $display("FAIL directed[%0d] %h*%h got=%h want=%h", i, ta[i], tb[i], got, te[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] te [4];
    logic [34:0] got;
    ta = '{32'h3F800001, 32'h3F800001, 32'h3F800003, 32'h3FFFFFFF};
    tb = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFF};
    te = '{32'h3F800002, 32'h3FC00002, 32'h3FC00004, 32'h407FFFFE};
    for (int i = 0; i < 4; i++) begin
      run_pair(ta[i], tb[i], got);
      vectors++;
      if (got !== {3'b000, te[i]}) begin
        miscompares++;
        $display("FAIL rounding[%0d] %h*%h got=%h want=%h", i, ta[i], tb[i], got, {3'b000, te[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] expq[$];
    logic [34:0] want;
    logic [34:0] got;
    logic [31:0] a, b;
    for (int i = 0; i < 400 + LAT; i++) begin
      if (i < 400) begin
        a = rnd_op();
        b = rnd_op();
        a_op = a;
        b_op = b;
        expq.push_back(ref_mul(a, b));
      end
      @(posedge clk);
      #1;
      if (expq.size() >= LAT || i >= 400) begin
        if (expq.size() > 0) begin
          want = expq.pop_front();
          got  = {exc_o, ovf_o, unf_o, res_o};
          vectors++;
          if (got !== want) begin
            miscompares++;
            $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [34:0] got;
    logic [34:0] dummy;
    run_pair(32'h40A00000, 32'h40400000, dummy);
    a_op = 32'h41200000;
    b_op = 32'h3FC00000;
    #2 rst = 1'b1;
    #1 got = {exc_o, ovf_o, unf_o, res_o};
    vectors++;
    if (got !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_midstream got=%h want=%h", got, 35'd0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    a_op = 32'h40400000;
    b_op = 32'hC0800000;
    repeat (LAT) @(posedge clk);
    #1 got = {exc_o, ovf_o, unf_o, res_o};
    vectors++;
    if (got !== {3'b000, 32'hC1400000}) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", got, {3'b000, 32'hC1400000});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
